fifo_rr_arbiter: RTL and testbench

- Packet-aware round-robin arbiter that drains NUM_IN first-word-fallthrough small FIFOs into one registered output stream.
- Grant is held for a whole packet; the end of a packet is marked by bit EOP_BIT of the data word.
- Sits between the per-port fallthrough FIFOs and a shared downstream datapath, for example a DMA or output queue.
- Downstream can apply backpressure through out_rdy.

---
 rtl/fifo_rr_arbiter.sv | 147 ++++++++++++++
 tb/tb_fifo_rr_arbiter.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: packet-aware round-robin arbiter that drains NUM_IN
// first-word-fallthrough FIFOs into a single registered output stream.
// The grant is held for a whole packet (PKT_MODE=1) until a word with
// bit EOP_BIT set has been transferred.
// Optional feature: define FIFO_ARB_PKT_CNT_EN to add the pkt_cnt output,
// a 16-bit wrapping count of completed packets per input.
module fifo_rr_arbiter #(
  parameter int NUM_IN   = 4,
  parameter int WIDTH    = 72,
  parameter int EOP_BIT  = 71,
  parameter int PKT_MODE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_empty,
  output logic [NUM_IN-1:0]       in_rd_en,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_rdy,
  output logic [NUM_IN-1:0]       grant,
  output logic                    busy
`ifdef FIFO_ARB_PKT_CNT_EN
  ,
  output logic [NUM_IN*16-1:0]    pkt_cnt
`endif
);

  localparam int IDXW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IDXW-1:0] last_idx;
  logic [IDXW-1:0] sel_idx;
  logic [IDXW-1:0] cand_idx;
  logic            sel_valid;
  logic            space;
  logic            fire;
  logic            sel_eop;
  logic [WIDTH-1:0] sel_word;
  int              cand;

  // Choose the source for this cycle: the locked owner, or the nearest
  // requester after the last grant (loop runs far-to-near so the nearest wins)
  always_comb begin
    sel_idx   = last_idx;
    sel_valid = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    if (state == LOCKED) begin
      sel_idx   = last_idx;
      sel_valid = !in_empty[last_idx];
    end else begin
      for (int k = NUM_IN; k >= 1; k--) begin
        cand     = (int'(last_idx) + k) % NUM_IN;
        cand_idx = IDXW'(cand);
        if (!in_empty[cand_idx]) begin
          sel_idx   = cand_idx;
          sel_valid = 1'b1;
        end
      end
    end
  end

  assign sel_word = in_data[sel_idx*WIDTH +: WIDTH];
  assign sel_eop  = sel_word[EOP_BIT];
  assign space    = !out_valid || out_rdy;
  assign fire     = space && sel_valid && !reset;
  assign busy     = (state == LOCKED);

  // Pop the selected FIFO only when a transfer actually happens
  always_comb begin
    in_rd_en = '0;
    if (fire) begin
      in_rd_en[sel_idx] = 1'b1;
    end
  end

  // Next-state logic: lock onto a multi-word packet, release on its EOP
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fire && (PKT_MODE != 0) && !sel_eop) begin
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (fire && sel_eop) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Output register: load on transfer, otherwise drain when consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (fire) begin
      out_data  <= sel_word;
      out_valid <= 1'b1;
    end else if (out_rdy) begin
      out_valid <= 1'b0;
    end
  end

  // Remember the owner of the latest transfer; reset points at the top input
  // so that input 0 has first priority
  always_ff @(posedge clk) begin
    if (reset) begin
      grant    <= '0;
      last_idx <= IDXW'(NUM_IN - 1);
    end else if (fire) begin
      grant    <= in_rd_en;
      last_idx <= sel_idx;
    end
  end

`ifdef FIFO_ARB_PKT_CNT_EN
  // Count packets whose EOP word has been transferred, per input
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt <= '0;
    end else if (fire && sel_eop) begin
      pkt_cnt[sel_idx*16 +: 16] <= pkt_cnt[sel_idx*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: self-checking bench for fifo_rr_arbiter.
// FIFOs are modelled as queues; a packet-level reference model predicts the
// read enables and output registers each cycle. Build with
// FIFO_ARB_PKT_CNT_EN defined to also check pkt_cnt.
`timescale 1ns/1ps
module tb_fifo_rr_arbiter;

  localparam int N    = 4;
  localparam int W    = 72;
  localparam int EOPB = 71;
  localparam int PM   = 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_empty;
  logic [N-1:0]   in_rd_en;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_rdy;
  logic [N-1:0]   grant;
  logic           busy;
`ifdef FIFO_ARB_PKT_CNT_EN
  logic [N*16-1:0] pkt_cnt;
`endif

  always #5 clk = ~clk;

  fifo_rr_arbiter #(.NUM_IN(N), .WIDTH(W), .EOP_BIT(EOPB), .PKT_MODE(PM)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_rdy   (out_rdy),
    .grant     (grant),
    .busy      (busy)
`ifdef FIFO_ARB_PKT_CNT_EN
    ,
    .pkt_cnt   (pkt_cnt)
`endif
  );

  // FIFO contents and artificial "appear empty" holds
  logic [W-1:0] fifo_q [N][$];
  logic [N-1:0] hold;

  // Reference model state
  int           m_last;
  int           m_owner;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic [N-1:0] m_grant;
  logic [15:0]  m_pkts [N];

  // Log of words accepted downstream
  logic [W-1:0] log_data [$];
  logic [N-1:0] log_grant [$];
  int           log_cycle [$];
  int           first_rd_cycle;
  int           cycle;

  int n_checks;
  int n_fail;

  function automatic logic [W-1:0] make_word(input int src, input int tag, input bit eop);
    logic [W-1:0] w;
    w = '0;
    w[15:0]  = tag[15:0];
    w[19:16] = src[3:0];
    w[EOPB]  = eop;
    return w;
  endfunction

  function automatic bit has_word(input int i);
    return (fifo_q[i].size() > 0) && !hold[i];
  endfunction

  task automatic drive_fifos();
    for (int i = 0; i < N; i++) begin
      if (fifo_q[i].size() > 0) in_data[i*W +: W] = fifo_q[i][0];
      else                      in_data[i*W +: W] = '0;
      in_empty[i] = !has_word(i);
    end
  endtask

  task automatic model_reset();
    m_last  = N - 1;
    m_owner = -1;
    m_valid = 1'b0;
    m_data  = '0;
    m_grant = '0;
    for (int i = 0; i < N; i++) m_pkts[i] = 16'd0;
  endtask

  task automatic clear_logs();
    log_data.delete();
    log_grant.delete();
    log_cycle.delete();
    first_rd_cycle = -1;
  endtask

  // One clock cycle: predict rd_en, advance the model on the edge, compare registers
  task automatic tick();
    int           sel;
    int           c;
    logic         space;
    logic         fire;
    logic [N-1:0] exp_rd;
    logic [N-1:0] dut_rd;
    logic [W-1:0] word;
    drive_fifos();
    #1;
    sel = -1;
    if (!reset) begin
      if (m_owner >= 0) begin
        if (has_word(m_owner)) sel = m_owner;
      end else begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (sel < 0 && has_word(c)) sel = c;
        end
      end
    end
    space  = !m_valid || out_rdy;
    fire   = space && (sel >= 0);
    exp_rd = '0;
    if (fire) exp_rd[sel] = 1'b1;
    n_checks++;
    if (in_rd_en !== exp_rd) begin
      n_fail++;
      $display("[TB] FAIL rd_en cycle %0d: got %b, expected %b", cycle, in_rd_en, exp_rd);
    end
    dut_rd = in_rd_en;
    if (dut_rd != '0 && first_rd_cycle < 0) first_rd_cycle = cycle;
    if (!reset && out_valid === 1'b1 && out_rdy) begin
      log_data.push_back(out_data);
      log_grant.push_back(grant);
      log_cycle.push_back(cycle);
    end
    @(posedge clk);
    cycle++;
    if (reset) begin
      model_reset();
    end else if (fire) begin
      word       = fifo_q[sel][0];
      m_data     = word;
      m_valid    = 1'b1;
      m_grant    = '0;
      m_grant[sel] = 1'b1;
      m_last     = sel;
      if (word[EOPB]) begin
        m_owner = -1;
        m_pkts[sel]++;
      end else if (PM != 0) begin
        m_owner = sel;
      end
    end else if (out_rdy) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (dut_rd[i] && fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
    end
    #1;
    drive_fifos();
    n_checks++;
    if (out_valid !== m_valid) begin
      n_fail++;
      $display("[TB] FAIL out_valid cycle %0d: got %b, expected %b", cycle, out_valid, m_valid);
    end
    n_checks++;
    if (out_data !== m_data) begin
      n_fail++;
      $display("[TB] FAIL out_data cycle %0d: got %h, expected %h", cycle, out_data, m_data);
    end
    n_checks++;
    if (grant !== m_grant) begin
      n_fail++;
      $display("[TB] FAIL grant cycle %0d: got %b, expected %b", cycle, grant, m_grant);
    end
    n_checks++;
    if (busy !== (m_owner >= 0)) begin
      n_fail++;
      $display("[TB] FAIL busy cycle %0d: got %b, expected %b", cycle, busy, (m_owner >= 0));
    end
`ifdef FIFO_ARB_PKT_CNT_EN
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (pkt_cnt[i*16 +: 16] !== m_pkts[i]) begin
        n_fail++;
        $display("[TB] FAIL pkt_cnt[%0d] cycle %0d: got %0d, expected %0d", i, cycle, pkt_cnt[i*16 +: 16], m_pkts[i]);
      end
    end
`endif
    @(negedge clk);
  endtask

  task automatic apply_reset();
    for (int i = 0; i < N; i++) fifo_q[i].delete();
    hold    = '0;
    out_rdy = 1'b1;
    reset   = 1'b1;
    tick();
    tick();
    reset   = 1'b0;
    clear_logs();
  endtask

  task automatic run_until_log(input int count, input int budget, input string name);
    for (int t = 0; t < budget && log_data.size() < count; t++) tick();
    n_checks++;
    if (log_data.size() != count) begin
      n_fail++;
      $display("[TB] FAIL %s word count: got %0d, expected %0d", name, log_data.size(), count);
    end
  endtask

  // Reset, then 10 idle cycles with everything empty
  task automatic test_reset();
    apply_reset();
    for (int t = 0; t < 10; t++) begin
      tick();
      n_checks++;
      if (in_rd_en !== '0 || out_valid !== 1'b0 || grant !== '0 || busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_idle: rd_en=%b out_valid=%b grant=%b busy=%b, expected all 0", in_rd_en, out_valid, grant, busy);
      end
    end
  endtask

  // Two 3-word packets on inputs 0 and 2, back to back
  task automatic test_back_to_back();
    int exp_tag;
    apply_reset();
    for (int j = 0; j < 3; j++) begin
      fifo_q[0].push_back(make_word(0, 16'h0A + j, j == 2));
      fifo_q[2].push_back(make_word(2, 16'h2A + j, j == 2));
    end
    run_until_log(6, 30, "back_to_back");
    for (int k = 0; k < log_data.size(); k++) begin
      exp_tag = (k < 3) ? (16'h0A + k) : (16'h2A + k - 3);
      n_checks++;
      if (int'(log_data[k][15:0]) != exp_tag || log_grant[k] !== ((k < 3) ? 4'b0001 : 4'b0100)
          || log_cycle[k] != first_rd_cycle + 1 + k) begin
        n_fail++;
        $display("[TB] FAIL back_to_back word %0d: got tag %h grant %b cycle %0d, expected tag %h grant %b cycle %0d",
                 k, log_data[k][15:0], log_grant[k], log_cycle[k], exp_tag, (k < 3) ? 4'b0001 : 4'b0100, first_rd_cycle + 1 + k);
      end
    end
    tick();
    tick();
  endtask

  // Locked owner runs dry mid-packet; the other requester must wait
  task automatic test_stall_gap();
    int exp_tag;
    apply_reset();
    for (int j = 0; j < 4; j++) fifo_q[1].push_back(make_word(1, 16'h1A + j, j == 3));
    for (int j = 0; j < 2; j++) fifo_q[3].push_back(make_word(3, 16'h3A + j, j == 1));
    tick();
    tick();
    hold[1] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      drive_fifos();
      #1;
      n_checks++;
      if (in_rd_en !== '0 || busy !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL stall_gap: rd_en=%b busy=%b, expected 0000 and 1", in_rd_en, busy);
      end
      tick();
    end
    hold[1] = 1'b0;
    run_until_log(6, 30, "stall_gap");
    for (int k = 0; k < log_data.size(); k++) begin
      exp_tag = (k < 4) ? (16'h1A + k) : (16'h3A + k - 4);
      n_checks++;
      if (int'(log_data[k][15:0]) != exp_tag) begin
        n_fail++;
        $display("[TB] FAIL stall_gap order %0d: got %h, expected %h", k, log_data[k][15:0], exp_tag);
      end
    end
    tick();
    tick();
  endtask

  // Single-word packets everywhere: grant rotates every cycle
  task automatic test_rotation();
    logic [N-1:0] exp_g;
    apply_reset();
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < N; i++) fifo_q[i].push_back(make_word(i, i*16 + j, 1'b1));
    run_until_log(12, 40, "rotation");
    for (int k = 0; k < log_data.size(); k++) begin
      exp_g = '0;
      exp_g[k % N] = 1'b1;
      n_checks++;
      if (log_grant[k] !== exp_g || int'(log_data[k][15:0]) != (k % N)*16 + k / N
          || log_cycle[k] != first_rd_cycle + 1 + k) begin
        n_fail++;
        $display("[TB] FAIL rotation word %0d: got grant %b tag %h cycle %0d, expected grant %b tag %h cycle %0d",
                 k, log_grant[k], log_data[k][15:0], log_cycle[k], exp_g, (k % N)*16 + k / N, first_rd_cycle + 1 + k);
      end
    end
    tick();
  endtask

  // Downstream stalls for 5 cycles mid-packet
  task automatic test_backpressure();
    logic [W-1:0] snap;
    apply_reset();
    for (int j = 0; j < 4; j++) fifo_q[0].push_back(make_word(0, 16'h50 + j, j == 3));
    tick();
    tick();
    out_rdy = 1'b0;
    snap = out_data;
    for (int t = 0; t < 5; t++) begin
      drive_fifos();
      #1;
      n_checks++;
      if (in_rd_en !== '0) begin
        n_fail++;
        $display("[TB] FAIL backpressure rd_en: got %b, expected 0000", in_rd_en);
      end
      tick();
      n_checks++;
      if (out_data !== snap || out_valid !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL backpressure hold: got %h valid %b, expected %h valid 1", out_data, out_valid, snap);
      end
    end
    out_rdy = 1'b1;
    run_until_log(4, 20, "backpressure");
    tick();
    tick();
    n_checks++;
    if (log_data.size() != 4) begin
      n_fail++;
      $display("[TB] FAIL backpressure duplicates: got %0d words, expected 4", log_data.size());
    end
    for (int k = 0; k < log_data.size(); k++) begin
      n_checks++;
      if (int'(log_data[k][15:0]) != 16'h50 + k) begin
        n_fail++;
        $display("[TB] FAIL backpressure order %0d: got %h, expected %h", k, log_data[k][15:0], 16'h50 + k);
      end
    end
  endtask

  // Random packets, holds and backpressure; check per-input order and packet contiguity
  task automatic test_random();
    logic [W-1:0] sent [N][$];
    logic [W-1:0] w;
    int total;
    int src;
    int len;
    int prev_src;
    bit in_pkt;
    int t;
    apply_reset();
    total = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(3) == 0) begin
        src = $urandom_range(N - 1);
        if (fifo_q[src].size() < 8) begin
          len = $urandom_range(4, 1);
          for (int j = 0; j < len; j++) begin
            w = make_word(src, total, j == len - 1);
            w[63:20] = {$urandom, $urandom};
            fifo_q[src].push_back(w);
            sent[src].push_back(w);
            total++;
          end
        end
      end
      for (int i = 0; i < N; i++) hold[i] = ($urandom_range(7) == 0);
      out_rdy = ($urandom_range(3) != 0);
      tick();
    end
    hold    = '0;
    out_rdy = 1'b1;
    t = 0;
    while (t < 500 && (fifo_q[0].size() + fifo_q[1].size() + fifo_q[2].size() + fifo_q[3].size() > 0 || out_valid)) begin
      tick();
      t++;
    end
    n_checks++;
    if (log_data.size() != total) begin
      n_fail++;
      $display("[TB] FAIL random word count: got %0d, expected %0d", log_data.size(), total);
    end
    prev_src = -1;
    in_pkt   = 1'b0;
    for (int k = 0; k < log_data.size(); k++) begin
      src = int'(log_data[k][19:16]);
      n_checks++;
      if (src >= N || sent[src].size() == 0 || log_data[k] !== sent[src][0] || (in_pkt && src != prev_src)) begin
        n_fail++;
        $display("[TB] FAIL random stream word %0d: got %h, expected next word of input %0d", k, log_data[k], in_pkt ? prev_src : src);
      end
      if (src < N && sent[src].size() > 0) void'(sent[src].pop_front());
      in_pkt   = !log_data[k][EOPB];
      prev_src = src;
    end
  endtask

  // Completed-packet counting, then a reset in the middle of a packet
  task automatic test_pkt_cnt_reset();
    apply_reset();
    for (int p = 0; p < 3; p++)
      for (int j = 0; j < 2; j++) fifo_q[2].push_back(make_word(2, p*16 + j, j == 1));
    run_until_log(6, 30, "pkt_cnt");
    tick();
`ifdef FIFO_ARB_PKT_CNT_EN
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (pkt_cnt[i*16 +: 16] !== ((i == 2) ? 16'd3 : 16'd0)) begin
        n_fail++;
        $display("[TB] FAIL pkt_cnt_final[%0d]: got %0d, expected %0d", i, pkt_cnt[i*16 +: 16], (i == 2) ? 3 : 0);
      end
    end
`endif
    for (int j = 0; j < 3; j++) fifo_q[1].push_back(make_word(1, 16'h70 + j, j == 2));
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_packet busy: got %b, expected 1", busy);
    end
    reset = 1'b1;
    drive_fifos();
    #1;
    n_checks++;
    if (in_rd_en !== '0) begin
      n_fail++;
      $display("[TB] FAIL rd_en_in_reset: got %b, expected 0000", in_rd_en);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || grant !== '0) begin
      n_fail++;
      $display("[TB] FAIL mid_packet_reset: got valid %b busy %b grant %b, expected 0 0 0000", out_valid, busy, grant);
    end
`ifdef FIFO_ARB_PKT_CNT_EN
    n_checks++;
    if (pkt_cnt !== '0) begin
      n_fail++;
      $display("[TB] FAIL pkt_cnt_reset: got %h, expected 0", pkt_cnt);
    end
`endif
    for (int i = 0; i < N; i++) fifo_q[i].delete();
    reset = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cycle    = 0;
    reset    = 1'b1;
    out_rdy  = 1'b0;
    hold     = '0;
    in_data  = '0;
    in_empty = '1;
    model_reset();
    clear_logs();
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_stall_gap();
    test_rotation();
    test_backpressure();
    test_random();
    test_pkt_cnt_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
